// File: rtl/blk_row_packer.sv
// Packs N-pixel beats into 8-pixel block rows (Y/Cr/Cb) and queues them in a
// first-word-fall-through row FIFO, flagging framing errors and dropped rows.
module blk_row_packer #(
    parameter int N     = 2,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         blk_valid,
    input  logic signed [N-1:0][7:0]     blk_data_y,
    input  logic signed [N-1:0][7:0]     blk_data_cr,
    input  logic signed [N-1:0][7:0]     blk_data_cb,
    input  logic                         blk_sob,
    input  logic                         blk_eob,
    input  logic                         blk_sof,
    output logic                         row_valid,
    input  logic                         row_ready,
    output logic signed [7:0][7:0]       row_data_y,
    output logic signed [7:0][7:0]       row_data_cr,
    output logic signed [7:0][7:0]       row_data_cb,
    output logic [2:0]                   row_idx,
    output logic                         row_sob,
    output logic                         row_eob,
    output logic                         row_sof,
    output logic [$clog2(DEPTH):0]       fill,
    output logic                         overflow,
    output logic                         sync_err
);

    localparam int BEATS = 8 / N;
    localparam int EW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = AW + 1;
    localparam int ENT_W = 3 * 64 + 3 + 3;

    logic [EW-1:0]          elem_q, elem_d, eff_elem_s;
    logic [2:0]             row_q, row_d, eff_row_s;
    logic signed [7:0][7:0] asm_y_q, asm_y_d, asm_cr_q, asm_cr_d, asm_cb_q, asm_cb_d;
    logic                   pend_sob_q, pend_sob_d, pend_sof_q, pend_sof_d;
    logic                   sync_err_q, sync_err_d;
    logic                   overflow_q, overflow_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   push_s, pop_s, accept_s, last_s;
    logic [ENT_W-1:0]       entry_s, head_s;
    logic [ENT_W-1:0]       mem_q [DEPTH];

    // Beat assembly: counters, lane placement, framing checks and row push.
    always_comb begin
        elem_d     = elem_q;
        row_d      = row_q;
        asm_y_d    = asm_y_q;
        asm_cr_d   = asm_cr_q;
        asm_cb_d   = asm_cb_q;
        pend_sob_d = pend_sob_q;
        pend_sof_d = pend_sof_q;
        sync_err_d = 1'b0;
        push_s     = 1'b0;
        last_s     = 1'b0;
        eff_elem_s = elem_q;
        eff_row_s  = row_q;
        if (blk_valid) begin
            // A start-of-block beat resynchronises; any partial state is abandoned.
            if (blk_sob) begin
                eff_elem_s = {EW{1'b0}};
                eff_row_s  = 3'd0;
                sync_err_d = (elem_q != {EW{1'b0}}) || (row_q != 3'd0);
            end else begin
                eff_elem_s = elem_q;
                eff_row_s  = row_q;
            end
            for (int k = 0; k < N; k++) begin
                asm_y_d[3'(int'(eff_elem_s) * N + k)]  = blk_data_y[k];
                asm_cr_d[3'(int'(eff_elem_s) * N + k)] = blk_data_cr[k];
                asm_cb_d[3'(int'(eff_elem_s) * N + k)] = blk_data_cb[k];
            end
            if (eff_elem_s == {EW{1'b0}}) begin
                pend_sob_d = blk_sob;
                pend_sof_d = blk_sob & blk_sof;
            end else begin
                pend_sob_d = pend_sob_q;
                pend_sof_d = pend_sof_q;
            end
            last_s = (eff_elem_s == EW'(BEATS - 1));
            if (blk_eob != (last_s && (eff_row_s == 3'd7))) begin
                sync_err_d = 1'b1;
            end else begin
                sync_err_d = sync_err_d;
            end
            if (last_s) begin
                push_s = 1'b1;
                elem_d = {EW{1'b0}};
                row_d  = eff_row_s + 3'd1;
            end else begin
                elem_d = eff_elem_s + EW'(1);
                row_d  = eff_row_s;
            end
        end else begin
            push_s = 1'b0;
        end
        entry_s = {asm_y_d, asm_cr_d, asm_cb_d, eff_row_s, pend_sob_d, blk_eob, pend_sof_d};
    end

    // FIFO control: a full FIFO still takes a row when a pop frees the slot.
    always_comb begin
        pop_s      = (fill_q != FW'(0)) && row_ready;
        accept_s   = push_s && ((fill_q < FW'(DEPTH)) || pop_s);
        overflow_d = overflow_q | (push_s & ~accept_s);
        wr_ptr_d   = accept_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({accept_s, pop_s})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Head-of-FIFO presentation, zeroed while empty.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (fill_q != FW'(0)) begin
            {row_data_y, row_data_cr, row_data_cb, row_idx, row_sob, row_eob, row_sof} = head_s;
        end else begin
            {row_data_y, row_data_cr, row_data_cb, row_idx, row_sob, row_eob, row_sof} = {ENT_W{1'b0}};
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_q     <= {EW{1'b0}};
            row_q      <= 3'd0;
            asm_y_q    <= 64'd0;
            asm_cr_q   <= 64'd0;
            asm_cb_q   <= 64'd0;
            pend_sob_q <= 1'b0;
            pend_sof_q <= 1'b0;
            sync_err_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            fill_q     <= {FW{1'b0}};
        end else begin
            elem_q     <= elem_d;
            row_q      <= row_d;
            asm_y_q    <= asm_y_d;
            asm_cr_q   <= asm_cr_d;
            asm_cb_q   <= asm_cb_d;
            pend_sob_q <= pend_sob_d;
            pend_sof_q <= pend_sof_d;
            sync_err_q <= sync_err_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
        end
    end

    // Row storage; contents are only visible through fill, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end
    end

    assign row_valid = (fill_q != FW'(0));
    assign fill      = fill_q;
    assign overflow  = overflow_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_blk_row_packer.sv
// Scoreboard bench for blk_row_packer (N=2, DEPTH=16): expected rows are queued
// as beats are driven and compared when the FIFO hands them out.
module tb_blk_row_packer;

    logic                     clk, rst, blk_valid, row_ready;
    logic signed [1:0][7:0]   blk_data_y, blk_data_cr, blk_data_cb;
    logic                     blk_sob, blk_eob, blk_sof;
    logic                     row_valid;
    logic signed [7:0][7:0]   row_data_y, row_data_cr, row_data_cb;
    logic [2:0]               row_idx;
    logic                     row_sob, row_eob, row_sof;
    logic [4:0]               fill;
    logic                     overflow, sync_err;

    typedef struct packed {
        logic [63:0] y;
        logic [63:0] cr;
        logic [63:0] cb;
        logic [2:0]  idx;
        logic        sob;
        logic        eob;
        logic        sof;
    } row_t;

    row_t exp_q[$];
    row_t got_r, exp_r;
    int   vecs = 0;
    int   errs = 0;
    int   exp_fill = 0;
    logic exp_ovf = 1'b0;

    blk_row_packer #(.N(2), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid),
        .blk_data_y(blk_data_y), .blk_data_cr(blk_data_cr), .blk_data_cb(blk_data_cb),
        .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof),
        .row_valid(row_valid), .row_ready(row_ready),
        .row_data_y(row_data_y), .row_data_cr(row_data_cr), .row_data_cb(row_data_cb),
        .row_idx(row_idx), .row_sob(row_sob), .row_eob(row_eob), .row_sof(row_sof),
        .fill(fill), .overflow(overflow), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int tag, input int r, input int i, input int ch);
        if (tag == 0 && ch == 0) return 8'(i);
        return 8'(tag * 37 + r * 8 + i + ch * 91);
    endfunction

    // Consumer side: every row handed out must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && row_valid && row_ready) begin
            got_r = {row_data_y, row_data_cr, row_data_cb, row_idx, row_sob, row_eob, row_sof};
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_row got=%h required=<none>", got_r);
            end else begin
                exp_r = exp_q.pop_front();
                if (got_r !== exp_r) begin
                    errs++;
                    $display("FAIL row_content got=%h required=%h", got_r, exp_r);
                end
            end
            exp_fill--;
        end
    end

    task automatic idle(input int n);
        blk_valid   = 1'b0;
        for (int c = 0; c < n; c++) begin
            blk_sob     = 1'($urandom);
            blk_eob     = 1'($urandom);
            blk_sof     = 1'($urandom);
            blk_data_y  = 16'($urandom);
            blk_data_cr = 16'($urandom);
            blk_data_cb = 16'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Drive beat b (0..31) of block 'tag'; returns 1 time unit after the capture edge.
    task automatic drive_beat(input int tag, input int b, input logic sof, input logic exp_err);
        int   r, e;
        row_t x;
        logic acc;
        r = b / 4;
        e = b % 4;
        blk_valid = 1'b1;
        blk_sob   = (b == 0);
        blk_eob   = (b == 31);
        blk_sof   = sof && (b == 0);
        for (int k = 0; k < 2; k++) begin
            blk_data_y[k]  = pix(tag, r, e * 2 + k, 0);
            blk_data_cr[k] = pix(tag, r, e * 2 + k, 1);
            blk_data_cb[k] = pix(tag, r, e * 2 + k, 2);
        end
        if (e == 3) begin
            acc = (exp_fill < 16) || (row_ready && exp_fill > 0);
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    x.y[i*8 +: 8]  = pix(tag, r, i, 0);
                    x.cr[i*8 +: 8] = pix(tag, r, i, 1);
                    x.cb[i*8 +: 8] = pix(tag, r, i, 2);
                end
                x.idx = 3'(r);
                x.sob = (r == 0);
                x.eob = (r == 7);
                x.sof = sof && (r == 0);
                exp_q.push_back(x);
                exp_fill++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk); #1;
        blk_valid = 1'b0;
        vecs++;
        if (sync_err !== exp_err) begin
            errs++;
            $display("FAIL sync_err tag=%0d beat=%0d got=%b required=%b", tag, b, sync_err, exp_err);
        end
        vecs++;
        if (fill !== 5'(exp_fill)) begin
            errs++;
            $display("FAIL fill tag=%0d beat=%0d got=%0d required=%0d", tag, b, fill, exp_fill);
        end
        vecs++;
        if (overflow !== exp_ovf) begin
            errs++;
            $display("FAIL overflow tag=%0d beat=%0d got=%b required=%b", tag, b, overflow, exp_ovf);
        end
    endtask

    task automatic send_block(input int tag, input logic sof);
        for (int b = 0; b < 32; b++) drive_beat(tag, b, sof, 1'b0);
    endtask

    task automatic drain();
        int c;
        row_ready = 1'b1;
        c = 0;
        while (fill != 5'd0 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        vecs++;
        if (fill !== 5'd0 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain fill=%0d left_in_scoreboard=%0d required=0", fill, exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_fill = 0;
        exp_ovf  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; blk_valid = 1'b0; row_ready = 1'b0;
        blk_sob = 1'b0; blk_eob = 1'b0; blk_sof = 1'b0;
        blk_data_y = 16'd0; blk_data_cr = 16'd0; blk_data_cb = 16'd0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if ({row_valid, fill, overflow, sync_err} !== 8'd0) begin
            errs++;
            $display("FAIL reset_ctrl got=%b required=0", {row_valid, fill, overflow, sync_err});
        end
        vecs++;
        if ({row_data_y, row_data_cr, row_data_cb, row_idx, row_sob, row_eob, row_sof} !== 198'd0) begin
            errs++;
            $display("FAIL reset_data got=%h required=0", {row_data_y, row_data_cr, row_data_cb, row_idx});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_one_block();
        row_ready = 1'b1;
        for (int b = 0; b < 32; b++) begin
            drive_beat(0, b, 1'b1, 1'b0);
            vecs++;
            if (row_valid !== (b % 4 == 3)) begin
                errs++;
                $display("FAIL row_latency beat=%0d got=%b required=%b", b, row_valid, (b % 4 == 3));
            end
            if (b % 4 == 3) begin
                vecs++;
                if (row_idx !== 3'(b / 4)) begin
                    errs++;
                    $display("FAIL row_idx got=%0d required=%0d", row_idx, b / 4);
                end
                for (int i = 0; i < 8; i++) begin
                    vecs++;
                    if (row_data_y[i] !== 8'(i)) begin
                        errs++;
                        $display("FAIL pixel_order lane=%0d got=%0d required=%0d", i, row_data_y[i], i);
                    end
                end
            end
        end
        idle(3);
        drain();
    endtask

    task automatic test_overflow();
        row_ready = 1'b0;
        send_block(1, 1'b1);
        idle(2);
        send_block(2, 1'b0);
        send_block(3, 1'b0);
        vecs++;
        if (fill !== 5'd16 || overflow !== 1'b1) begin
            errs++;
            $display("FAIL overflow_sat fill=%0d ovf=%b required fill=16 ovf=1", fill, overflow);
        end
        drain();
        vecs++;
        if (overflow !== 1'b1) begin
            errs++;
            $display("FAIL overflow_sticky got=%b required=1", overflow);
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        row_ready = 1'b0;
        send_block(8, 1'b1);
        send_block(9, 1'b0);
        for (int b = 0; b < 3; b++) drive_beat(10, b, 1'b0, 1'b0);
        row_ready = 1'b1;
        drive_beat(10, 3, 1'b0, 1'b0);
        vecs++;
        if (fill !== 5'd16 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL push_pop_full fill=%0d ovf=%b required fill=16 ovf=0", fill, overflow);
        end
        for (int b = 4; b < 32; b++) drive_beat(10, b, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_sob_resync();
        row_ready = 1'b1;
        for (int b = 0; b < 6; b++) drive_beat(4, b, 1'b0, 1'b0);
        drive_beat(5, 0, 1'b1, 1'b1);
        for (int b = 1; b < 32; b++) drive_beat(5, b, 1'b1, 1'b0);
        idle(2);
        drain();
    endtask

    task automatic test_reset_mid();
        row_ready = 1'b0;
        for (int b = 0; b < 10; b++) drive_beat(6, b, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        vecs++;
        if (fill !== 5'd0 || row_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid fill=%0d row_valid=%b required 0/0", fill, row_valid);
        end
        exp_q.delete();
        exp_fill = 0;
        exp_ovf  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        row_ready = 1'b1;
        send_block(7, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_one_block();
        test_overflow();
        test_push_pop_full();
        test_sob_resync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/blk_row_packer.md
BLK_ROW_PACKER -- requirements
Module: blk_row_packer

Interface
REQ-001 SHALL have parameter N, default 2, pixels per input beat; 8 % N == 0.
REQ-002 SHALL have parameter DEPTH, default 16, row FIFO depth; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port blk_valid  input  1  input beat strobe; no backpressure is possible.
REQ-006 SHALL have ports blk_data_y/cr/cb  input  signed [N-1:0][7:0]  pixels of beat; lane 0 is leftmost.
REQ-007 SHALL have ports blk_sob / blk_eob / blk_sof  input  1  each qualified by blk_valid.
REQ-008 SHALL have port row_valid  output  1  row available (FIFO not empty).
REQ-009 SHALL have port row_ready  input  1  consumer accepts row when high with row_valid.
REQ-010 SHALL have ports row_data_y/cr/cb  output  signed [7:0][7:0]  8 pixels of one block row; index 0 leftmost.
REQ-011 SHALL have port row_idx  output  3  row number 0..7 inside block.
REQ-012 SHALL have ports row_sob / row_eob / row_sof  output  1  row is first row of block / last row of block / first row of frame.
REQ-013 SHALL have port fill  output  $clog2(DEPTH)+1  rows stored.
REQ-014 SHALL have port overflow  output  1  sticky, row dropped.
REQ-015 SHALL have port sync_err  output  1  one-cycle pulse on framing error.

Function
REQ-016 SHALL keep beat counter elem (0..8/N-1) and row counter row (0..7); both advance only on blk_valid.
REQ-017 SHALL write beat lanes k into row positions elem*N+k of an assembly register.
REQ-018 SHALL on beat with elem==8/N-1 push {assembled row incl. current beat, row, sob flag, eob flag, sof flag} to FIFO, set elem=0, row=row+1 mod 8.
REQ-019 SHALL latch blk_sof (with blk_sob) into pending sof flag attached to the row whose first beat carried it; row_sof implies row_sob.
REQ-020 SHALL on blk_sob beat force elem=0, row=0 before writing; if elem!=0 or row!=0 beforehand, discard partial data and pulse sync_err next cycle.
REQ-021 SHALL pulse sync_err if blk_eob occurs on a beat other than elem==8/N-1 with row==7, or if a beat with elem==8/N-1, row==7 lacks blk_eob; row is still pushed with row_eob = blk_eob.
REQ-022 SHALL present FIFO first-word-fall-through: row completed on cycle t appears with row_valid=1 on t+1 when FIFO was empty.
REQ-023 SHALL pop on row_valid && row_ready; outputs hold stable while row_valid && !row_ready.
REQ-024 SHALL accept push when fill<DEPTH, or fill==DEPTH with a pop in the same cycle; otherwise drop row, leave FIFO unchanged, set overflow.
REQ-025 SHALL update fill: +1 push only, -1 pop only, unchanged on push+pop; pop on empty impossible (row_valid=0).
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH with no lost or duplicated rows.
REQ-027 SHALL ignore all input flags and data when blk_valid=0.
REQ-028 SHALL retain overflow until reset; sync_err and overflow have no effect on subsequent counting beyond REQ-020.

Reset
REQ-029 SHALL on rst asynchronously clear elem, row, pending sof, FIFO pointers, fill=0, row_valid=0, overflow=0, sync_err=0.
REQ-030 SHALL drive row_data_*, row_idx, row_sob/eob/sof to 0 while fill==0 and during reset.
REQ-031 SHALL on reset mid-block discard partial row and stored rows; first beat after reset treated as elem=0, row=0.

Verification
REQ-032 SHALL verify: one block, N=2, 32 consecutive beats, sof+sob on beat 0, eob on beat 31, row_ready=1 -> 8 rows, row_idx 0..7, first row row_sof=row_sob=1, last row_eob=1, each row appears 1 cycle after its 4th beat, sync_err never.
REQ-033 SHALL verify: pixel ordering, beat values (2e,2e+1) for elem e -> row_data_y[i]==i for all i.
REQ-034 SHALL verify: row_ready=0, DEPTH=16, 3 blocks (24 rows) -> fill saturates 16, overflow=1, then draining yields exactly rows 0..15 in order.
REQ-035 SHALL verify: push and pop same cycle at fill==16 -> row accepted, fill stays 16, overflow stays 0.
REQ-036 SHALL verify: blk_sob on beat with elem==2 -> sync_err pulse, partial row dropped, new block rows 0..7 correct.
REQ-037 SHALL verify: rst asserted after 10 beats with 2 rows queued -> fill=0, row_valid=0 immediately; next 32-beat block outputs 8 correct rows.
